// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command receiver.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    POP      = 3'd1,
    EXEC     = 3'd2,
    TX_WAIT  = 3'd3,
    TX_SEND  = 3'd4,
    RX_DRAIN = 3'd5
  } state_e;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_7     = 8'h37;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_R     = 8'h72;
  localparam logic [7:0] CH_RU    = 8'h52;
  localparam logic [7:0] CH_ERR   = 8'h3F;

endpackage

// File: rtl/uart_cmd_rx_cmd_decode.sv
// Combinational command decoder: maps one received byte plus the current
// pattern/divider settings onto their next values, a legal flag and the
// byte to echo back to the host.
module cmd_decode
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DIV_INIT = 2,
  parameter int unsigned DIV_MIN  = 1,
  parameter int unsigned DIV_MAX  = 20,
  parameter int unsigned DIV_STEP = 2
) (
  input  logic [7:0] byte_i,
  input  logic [2:0] ctrl_i,
  input  logic [7:0] divider_i,
  output logic [2:0] ctrl_o,
  output logic [7:0] divider_o,
  output logic       legal_o,
  output logic [7:0] echo_o
);

  // Divider math runs in 9 bits so an increment near 255 cannot wrap.
  localparam logic [8:0] DivMin9      = 9'(DIV_MIN);
  localparam logic [8:0] DivMax9      = 9'(DIV_MAX);
  localparam logic [8:0] DivStep9     = 9'(DIV_STEP);
  localparam logic [8:0] PlusThresh9  = 9'(DIV_MAX - DIV_STEP + 1);
  localparam logic [8:0] MinusThresh9 = 9'(DIV_MIN + DIV_STEP - 1);
  localparam logic [7:0] DivInit8     = 8'(DIV_INIT);

  logic [8:0] div9;

  // Decode the byte; anything unrecognised leaves settings alone and echoes '?'.
  always_comb begin
    div9      = {1'b0, divider_i};
    ctrl_o    = ctrl_i;
    divider_o = divider_i;
    legal_o   = 1'b0;
    echo_o    = CH_ERR;
    if (byte_i >= CH_0 && byte_i <= CH_7) begin
      ctrl_o  = byte_i[2:0];
      legal_o = 1'b1;
      echo_o  = byte_i;
    end else if (byte_i == CH_PLUS) begin
      if (div9 >= PlusThresh9) begin
        divider_o = 8'(DivMax9);
      end else begin
        divider_o = 8'(div9 + DivStep9);
      end
      legal_o = 1'b1;
      echo_o  = CH_PLUS;
    end else if (byte_i == CH_MINUS) begin
      if (div9 <= MinusThresh9) begin
        divider_o = 8'(DivMin9);
      end else begin
        divider_o = 8'(div9 - DivStep9);
      end
      legal_o = 1'b1;
      echo_o  = CH_MINUS;
    end else if (byte_i == CH_R || byte_i == CH_RU) begin
      ctrl_o    = 3'd0;
      divider_o = DivInit8;
      legal_o   = 1'b1;
      echo_o    = byte_i;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: pops one byte at a time from the board UART,
// updates the animation pattern/divider, and optionally echoes the byte.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DIV_INIT = 2,
  parameter int unsigned DIV_MIN  = 1,
  parameter int unsigned DIV_MAX  = 20,
  parameter int unsigned DIV_STEP = 2,
  parameter bit          ECHO_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rxdata,
  input  logic       rxready,
  output logic       rxclk,
  output logic [7:0] txdata,
  input  logic       txready,
  output logic       txclk,
  output logic [2:0] ctrl,
  output logic [7:0] divider,
  output logic       cmd_valid,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] DivInit8 = 8'(DIV_INIT);

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [7:0] divider_q, divider_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] txdata_q, txdata_d;
  logic       rxclk_q, rxclk_d;
  logic       txclk_q, txclk_d;
  logic       cmd_valid_q, cmd_valid_d;

  logic [2:0] dec_ctrl;
  logic [7:0] dec_divider;
  logic       dec_legal;
  logic [7:0] dec_echo;

  cmd_decode #(
    .DIV_INIT (DIV_INIT),
    .DIV_MIN  (DIV_MIN),
    .DIV_MAX  (DIV_MAX),
    .DIV_STEP (DIV_STEP)
  ) u_decode (
    .byte_i    (byte_q),
    .ctrl_i    (ctrl_q),
    .divider_i (divider_q),
    .ctrl_o    (dec_ctrl),
    .divider_o (dec_divider),
    .legal_o   (dec_legal),
    .echo_o    (dec_echo)
  );

  // State and output registers; reset abandons any byte in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      ctrl_q      <= 3'd0;
      divider_q   <= DivInit8;
      err_cnt_q   <= 8'h00;
      txdata_q    <= 8'h00;
      rxclk_q     <= 1'b0;
      txclk_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      ctrl_q      <= ctrl_d;
      divider_q   <= divider_d;
      err_cnt_q   <= err_cnt_d;
      txdata_q    <= txdata_d;
      rxclk_q     <= rxclk_d;
      txclk_q     <= txclk_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  // Next-state logic; strobes are registered so they are one clean cycle wide.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    ctrl_d      = ctrl_q;
    divider_d   = divider_q;
    err_cnt_d   = err_cnt_q;
    txdata_d    = txdata_q;
    rxclk_d     = 1'b0;
    txclk_d     = 1'b0;
    cmd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxready) begin
          byte_d  = rxdata;
          state_d = POP;
        end
      end
      POP: begin
        rxclk_d = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        ctrl_d      = dec_ctrl;
        divider_d   = dec_divider;
        cmd_valid_d = dec_legal;
        if (!dec_legal && err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        if (ECHO_EN) begin
          txdata_d = dec_echo;
          state_d  = TX_WAIT;
        end else begin
          state_d = RX_DRAIN;
        end
      end
      TX_WAIT: begin
        if (txready) begin
          txclk_d = 1'b1;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        state_d = RX_DRAIN;
      end
      RX_DRAIN: begin
        if (!rxready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rxclk     = rxclk_q;
  assign txclk     = txclk_q;
  assign txdata    = txdata_q;
  assign ctrl      = ctrl_q;
  assign divider   = divider_q;
  assign cmd_valid = cmd_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx with a behavioural command model.
module tb_uart_cmd_rx;

  logic       clk;
  logic       rst_n;
  logic [7:0] rxdata;
  logic       rxready;
  logic       rxclk;
  logic [7:0] txdata;
  logic       txready;
  logic       txclk;
  logic [2:0] ctrl;
  logic [7:0] divider;
  logic       cmd_valid;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int mCtrl;
  int mDiv;
  int mErr;

  uart_cmd_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxdata    (rxdata),
    .rxready   (rxready),
    .rxclk     (rxclk),
    .txdata    (txdata),
    .txready   (txready),
    .txclk     (txclk),
    .ctrl      (ctrl),
    .divider   (divider),
    .cmd_valid (cmd_valid),
    .err_cnt   (err_cnt)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: applies one command using the plain rules of the protocol.
  function automatic void model_apply(input logic [7:0] b, output logic [7:0] echo, output bit legal);
    int v;
    v = int'(b);
    legal = 1'b1;
    echo = b;
    if (v >= 48 && v <= 55) begin
      mCtrl = v - 48;
    end else if (v == 43) begin
      mDiv = (mDiv + 2 > 20) ? 20 : mDiv + 2;
    end else if (v == 45) begin
      mDiv = (mDiv - 2 < 1) ? 1 : mDiv - 2;
    end else if (v == 114 || v == 82) begin
      mCtrl = 0;
      mDiv = 2;
    end else begin
      legal = 1'b0;
      echo = 8'h3F;
      mErr = (mErr >= 255) ? 255 : mErr + 1;
    end
  endfunction

  function automatic bit is_legal(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h37) || b == 8'h2B || b == 8'h2D || b == 8'h72 || b == 8'h52;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    rxready = 1'b0;
    txready = 1'b1;
    rxdata = 8'h00;
    mCtrl = 0;
    mDiv = 2;
    mErr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one byte with txready assumed high and records what the DUT did.
  task automatic send_byte(input logic [7:0] b, output int rxLat, output int validLat,
                           output int nRx, output int nValid, output int nTx, output logic [7:0] txByte);
    rxLat = -1;
    validLat = -1;
    nRx = 0;
    nValid = 0;
    nTx = 0;
    txByte = 8'h00;
    @(negedge clk);
    rxdata = b;
    rxready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (rxclk) begin
        nRx++;
        if (rxLat < 0) rxLat = c;
        rxready = 1'b0;
      end
      if (cmd_valid) begin
        nValid++;
        if (validLat < 0) validLat = c;
      end
      if (txclk) begin
        nTx++;
        txByte = txdata;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rxclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_rxclk got %0b want 0", rxclk); end
    checks++; if (txclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_txclk got %0b want 0", txclk); end
    checks++; if (txdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_txdata got %h want 00", txdata); end
    checks++; if (ctrl !== 3'd0) begin errors++; $display("[TB] FAIL reset_ctrl got %0d want 0", ctrl); end
    checks++; if (divider !== 8'd2) begin errors++; $display("[TB] FAIL reset_divider got %0d want 2", divider); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_valid got %0b want 0", cmd_valid); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_digit();
    int rxLat, validLat, nRx, nValid, nTx;
    logic [7:0] txByte;
    do_reset();
    send_byte(8'h35, rxLat, validLat, nRx, nValid, nTx, txByte);
    checks++; if (rxLat !== 2) begin errors++; $display("[TB] FAIL digit_rxclk_latency got %0d want 2", rxLat); end
    checks++; if (validLat !== 3) begin errors++; $display("[TB] FAIL digit_update_latency got %0d want 3", validLat); end
    checks++; if (nRx !== 1) begin errors++; $display("[TB] FAIL digit_rxclk_count got %0d want 1", nRx); end
    checks++; if (nValid !== 1) begin errors++; $display("[TB] FAIL digit_cmd_valid_count got %0d want 1", nValid); end
    checks++; if (nTx !== 1) begin errors++; $display("[TB] FAIL digit_txclk_count got %0d want 1", nTx); end
    checks++; if (txByte !== 8'h35) begin errors++; $display("[TB] FAIL digit_echo got %h want 35", txByte); end
    checks++; if (ctrl !== 3'd5) begin errors++; $display("[TB] FAIL digit_ctrl got %0d want 5", ctrl); end
    checks++; if (divider !== 8'd2) begin errors++; $display("[TB] FAIL digit_divider got %0d want 2", divider); end
  endtask

  task automatic test_plus_saturate();
    int rxLat, validLat, nRx, nValid, nTx, want;
    logic [7:0] txByte;
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      send_byte(8'h2B, rxLat, validLat, nRx, nValid, nTx, txByte);
      want = (2 + 2 * i > 20) ? 20 : 2 + 2 * i;
      checks++; if (divider !== 8'(want)) begin errors++; $display("[TB] FAIL plus_divider step %0d got %0d want %0d", i, divider, want); end
      checks++; if (nValid !== 1) begin errors++; $display("[TB] FAIL plus_cmd_valid step %0d got %0d want 1", i, nValid); end
      checks++; if (txByte !== 8'h2B) begin errors++; $display("[TB] FAIL plus_echo step %0d got %h want 2b", i, txByte); end
    end
  endtask

  task automatic test_minus_saturate();
    int rxLat, validLat, nRx, nValid, nTx;
    logic [7:0] txByte;
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      send_byte(8'h2D, rxLat, validLat, nRx, nValid, nTx, txByte);
      checks++; if (divider !== 8'd1) begin errors++; $display("[TB] FAIL minus_divider step %0d got %0d want 1", i, divider); end
      checks++; if (nValid !== 1) begin errors++; $display("[TB] FAIL minus_cmd_valid step %0d got %0d want 1", i, nValid); end
      checks++; if (txByte !== 8'h2D) begin errors++; $display("[TB] FAIL minus_echo step %0d got %h want 2d", i, txByte); end
    end
  endtask

  task automatic test_illegal();
    int rxLat, validLat, nRx, nValid, nTx;
    logic [7:0] txByte;
    logic [7:0] b;
    do_reset();
    send_byte(8'h41, rxLat, validLat, nRx, nValid, nTx, txByte);
    checks++; if (ctrl !== 3'd0) begin errors++; $display("[TB] FAIL illegal_ctrl got %0d want 0", ctrl); end
    checks++; if (divider !== 8'd2) begin errors++; $display("[TB] FAIL illegal_divider got %0d want 2", divider); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL illegal_err_cnt got %0d want 1", err_cnt); end
    checks++; if (txByte !== 8'h3F) begin errors++; $display("[TB] FAIL illegal_echo got %h want 3f", txByte); end
    checks++; if (nValid !== 0) begin errors++; $display("[TB] FAIL illegal_cmd_valid got %0d want 0", nValid); end
    for (int i = 2; i <= 301; i++) begin
      do b = 8'($urandom_range(0, 255)); while (is_legal(b));
      send_byte(b, rxLat, validLat, nRx, nValid, nTx, txByte);
      if (i == 254 || i == 255 || i == 256) begin
        checks++; if (err_cnt !== 8'((i > 255) ? 255 : i)) begin errors++; $display("[TB] FAIL illegal_err_ramp n=%0d got %0d", i, err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL illegal_err_saturate got %0d want 255", err_cnt); end
  endtask

  task automatic test_txready_stall();
    int nRx, nTx, rxLat, validLat, nValid;
    logic [7:0] txByte;
    do_reset();
    txready = 1'b0;
    nRx = 0;
    nTx = 0;
    @(negedge clk);
    rxdata = 8'h33;
    rxready = 1'b1;
    for (int c = 0; c < 55; c++) begin
      @(posedge clk);
      #1;
      if (rxclk) nRx++;
      if (txclk) nTx++;
    end
    checks++; if (nRx !== 1) begin errors++; $display("[TB] FAIL stall_rxclk_count got %0d want 1", nRx); end
    checks++; if (nTx !== 0) begin errors++; $display("[TB] FAIL stall_txclk_held got %0d want 0", nTx); end
    checks++; if (ctrl !== 3'd3) begin errors++; $display("[TB] FAIL stall_ctrl got %0d want 3", ctrl); end
    @(negedge clk);
    txready = 1'b1;
    nRx = 0;
    nTx = 0;
    txByte = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rxclk) nRx++;
      if (txclk) begin nTx++; txByte = txdata; end
    end
    checks++; if (nTx !== 1) begin errors++; $display("[TB] FAIL stall_release_txclk got %0d want 1", nTx); end
    checks++; if (txByte !== 8'h33) begin errors++; $display("[TB] FAIL stall_release_echo got %h want 33", txByte); end
    checks++; if (nRx !== 0) begin errors++; $display("[TB] FAIL stall_drain_rxclk got %0d want 0", nRx); end
    @(negedge clk);
    rxready = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h34, rxLat, validLat, nRx, nValid, nTx, txByte);
    checks++; if (rxLat !== 2) begin errors++; $display("[TB] FAIL stall_next_rxclk_latency got %0d want 2", rxLat); end
    checks++; if (ctrl !== 3'd4) begin errors++; $display("[TB] FAIL stall_next_ctrl got %0d want 4", ctrl); end
  endtask

  task automatic test_reset_cmd();
    int rxLat, validLat, nRx, nValid, nTx;
    logic [7:0] txByte;
    do_reset();
    send_byte(8'h36, rxLat, validLat, nRx, nValid, nTx, txByte);
    repeat (4) send_byte(8'h2B, rxLat, validLat, nRx, nValid, nTx, txByte);
    checks++; if (ctrl !== 3'd6) begin errors++; $display("[TB] FAIL rcmd_setup_ctrl got %0d want 6", ctrl); end
    checks++; if (divider !== 8'd10) begin errors++; $display("[TB] FAIL rcmd_setup_divider got %0d want 10", divider); end
    send_byte(8'h52, rxLat, validLat, nRx, nValid, nTx, txByte);
    checks++; if (ctrl !== 3'd0) begin errors++; $display("[TB] FAIL rcmd_ctrl got %0d want 0", ctrl); end
    checks++; if (divider !== 8'd2) begin errors++; $display("[TB] FAIL rcmd_divider got %0d want 2", divider); end
    checks++; if (txByte !== 8'h52) begin errors++; $display("[TB] FAIL rcmd_echo got %h want 52", txByte); end
    checks++; if (nValid !== 1) begin errors++; $display("[TB] FAIL rcmd_cmd_valid got %0d want 1", nValid); end
  endtask

  task automatic test_reset_mid_tx();
    int nTx;
    do_reset();
    txready = 1'b0;
    @(negedge clk);
    rxdata = 8'h35;
    rxready = 1'b1;
    repeat (3) @(negedge clk);
    rxready = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ctrl !== 3'd5) begin errors++; $display("[TB] FAIL midrst_inflight_ctrl got %0d want 5", ctrl); end
    rst_n = 1'b0;
    #1;
    checks++; if (ctrl !== 3'd0) begin errors++; $display("[TB] FAIL midrst_ctrl got %0d want 0", ctrl); end
    checks++; if (divider !== 8'd2) begin errors++; $display("[TB] FAIL midrst_divider got %0d want 2", divider); end
    checks++; if (txdata !== 8'h00) begin errors++; $display("[TB] FAIL midrst_txdata got %h want 00", txdata); end
    checks++; if (txclk !== 1'b0 || rxclk !== 1'b0 || cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_strobes got tx=%0b rx=%0b v=%0b want 0", txclk, rxclk, cmd_valid); end
    txready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    nTx = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (txclk) nTx++;
    end
    checks++; if (nTx !== 0) begin errors++; $display("[TB] FAIL midrst_no_echo got %0d want 0", nTx); end
  endtask

  task automatic test_random();
    int rxLat, validLat, nRx, nValid, nTx, sel;
    logic [7:0] txByte, b, echo;
    bit legal;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: b = 8'h30 + 8'($urandom_range(0, 7));
        4: b = 8'h2B;
        5: b = 8'h2D;
        6: b = 8'h72;
        7: b = 8'h52;
        default: b = 8'($urandom_range(0, 255));
      endcase
      model_apply(b, echo, legal);
      send_byte(b, rxLat, validLat, nRx, nValid, nTx, txByte);
      checks++; if (ctrl !== 3'(mCtrl) || divider !== 8'(mDiv) || err_cnt !== 8'(mErr)) begin
        errors++; $display("[TB] FAIL random_state byte %h got c=%0d d=%0d e=%0d want c=%0d d=%0d e=%0d", b, ctrl, divider, err_cnt, mCtrl, mDiv, mErr);
      end
      checks++; if (txByte !== echo || nValid !== int'(legal)) begin
        errors++; $display("[TB] FAIL random_echo byte %h got echo=%h v=%0d want echo=%h v=%0d", b, txByte, nValid, echo, legal);
      end
    end
  endtask

  // Runs each scenario in turn, then prints the summary line.
  initial begin
    rst_n = 1'b0;
    rxready = 1'b0;
    txready = 1'b1;
    rxdata = 8'h00;
    test_reset();
    test_digit();
    test_plus_saturate();
    test_minus_saturate();
    test_illegal();
    test_txready_stall();
    test_reset_cmd();
    test_reset_mid_tx();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Receive-side command decoder for the board UART byte interface (rxdata/rxready/rxclk), with echo on the transmit side (txdata/txready/txclk).
- Decodes single ASCII bytes into the idle-animation pattern select (ctrl) and speed divider, so the host can drive the same controls the push-buttons drive.
- Sits between the board UART port pins and the animation multiplexer in top.

Parameters:
- DIV_INIT, 2, divider value after reset and after the 'r'/'R' command.
- DIV_MIN, 1, lower saturation bound of the divider.
- DIV_MAX, 20, upper saturation bound of the divider.
- DIV_STEP, 2, increment/decrement per '+'/'-' command.
- ECHO_EN, 1, 1 = echo each processed byte on the tx side; 0 = skip the echo states entirely.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rxdata  in  8  received byte; valid while rxready=1.
- rxready  in  1  level: a received byte is available.
- rxclk  out  1  one-cycle pop strobe; consumes the current rx byte.
- txdata  out  8  byte to transmit.
- txready  in  1  level: transmitter can accept a byte.
- txclk  out  1  one-cycle send strobe; txdata must be valid in that cycle.
- ctrl  out  3  selected animation pattern.
- divider  out  8  animation clock-divider limit.
- cmd_valid  out  1  one-cycle pulse when a legal command updates ctrl/divider.
- err_cnt  out  8  count of illegal bytes, saturating at 255.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rxclk=0, txclk=0, txdata=0, ctrl=0, divider=DIV_INIT, cmd_valid=0, err_cnt=0.
- FSM states: IDLE, POP, EXEC, TX_WAIT, TX_SEND, RX_DRAIN.
- IDLE: when rxready=1, latch rxdata into byte_q and go to POP.
- POP: rxclk=1 for exactly one cycle, then go to EXEC.
- EXEC: decode byte_q, update registers, then go to TX_WAIT if ECHO_EN=1, else RX_DRAIN.
  - 0x30..0x37 ('0'..'7'): ctrl <= byte_q[2:0]; cmd_valid=1; echo byte = byte_q.
  - 0x2B ('+'): if divider >= DIV_MAX-DIV_STEP+1, divider <= DIV_MAX; else divider += DIV_STEP. cmd_valid=1; echo '+'.
  - 0x2D ('-'): if divider <= DIV_MIN+DIV_STEP-1, divider <= DIV_MIN; else divider -= DIV_STEP. cmd_valid=1; echo '-'.
  - 0x72/0x52 ('r'/'R'): ctrl <= 0, divider <= DIV_INIT; cmd_valid=1; echo byte_q.
  - Any other byte: ctrl and divider unchanged; err_cnt += 1, saturating at 255; cmd_valid=0; echo 0x3F ('?').
  - A saturated '+'/'-' (no value change) still counts as legal: cmd_valid=1.
- TX_WAIT: txdata holds the echo byte; wait for txready=1, then go to TX_SEND. No timeout.
- TX_SEND: txclk=1 for one cycle, txdata stable, then go to RX_DRAIN.
- RX_DRAIN: wait for rxready=0, then go to IDLE. This guards against re-reading the same byte when the source drops rxready late.
- Latency: rxready rise to rxclk = 2 cycles; rxready rise to ctrl/divider update visible = 3 cycles.
- At most one byte is in flight; a new byte is not accepted until the FSM returns to IDLE. No buffering.
- divider arithmetic is done in 9 bits to avoid wrap; the result is always within [DIV_MIN, DIV_MAX].
- Reset asserted mid-operation: FSM returns to IDLE immediately, strobes drop the same instant, and the in-flight byte is discarded without echo.
- txdata holds its last value outside TX_WAIT/TX_SEND.

Decomposition:
- Package uart_cmd_pkg:
  - state enum: IDLE, POP, EXEC, TX_WAIT, TX_SEND, RX_DRAIN.
  - ASCII constants: CH_0=0x30, CH_7=0x37, CH_PLUS=0x2B, CH_MINUS=0x2D, CH_R=0x72, CH_RU=0x52, CH_ERR=0x3F.
- One sub-module, cmd_decode: purely combinational; maps byte_q, ctrl and divider to next ctrl, next divider, legal flag and echo byte. The FSM and registers stay in uart_cmd_rx.

Test Plan:
- Reset, then rxdata=0x35 with rxready held 1 until rxclk, txready=1 -> rxclk pulse 2 cycles after rxready rise; ctrl=5; cmd_valid pulse once; txclk pulse with txdata=0x35.
- Eleven '+' bytes from reset -> divider steps 4,6,...,20 and stays 20; the 10th and 11th bytes still give cmd_valid=1.
- Two '-' bytes from reset (divider=2) -> divider=1 after the first, stays 1 after the second; echo 0x2D each time.
- Byte 0x41 ('A') -> ctrl/divider unchanged, err_cnt=1, echo 0x3F, cmd_valid=0; send 300 bad bytes -> err_cnt=255.
- Hold txready=0 for 50 cycles after '3' -> txclk stays 0 and no second rxclk occurs while rxready stays 1; release txready -> one txclk; FSM returns to IDLE only after rxready=0.
- Set ctrl=6 and divider=10, then send 'R' -> ctrl=0, divider=2; separately, assert rst_n=0 during TX_WAIT -> all outputs return to reset values and no txclk is issued.
